// File: rtl/uart_msg_sender.sv
// uart_msg_sender: builds a framed ASCII message and shifts it out as 8N1 UART.
//   Message: PREFIX bytes, '0'+chan, ':', payload (raw or uppercase hex), optional CR LF.
//   Bytes follow each other with no idle gap; the next byte is preloaded during the stop bit.
// Ports:
//   clk    system clock
//   rst    asynchronous reset, active-low
//   start  one-cycle send request, sampled only in IDLE
//   chan   channel index, accepted when < N_CHAN
//   datos  payload, most significant byte sent first
//   tx     UART line, idle high, driven from a register
//   busy   high from the cycle after an accepted start until the last stop bit ends
//   done   one-cycle pulse once the whole message has been sent
//   err    one-cycle pulse when a start is rejected for an out-of-range channel
module uart_msg_sender #(
  parameter int          CLK_DIV    = 434,
  parameter int          PREFIX_LEN = 2,
  parameter logic [63:0] PREFIX     = 64'h0000_0000_0000_543D,
  parameter int          DATA_BYTES = 1,
  parameter int          N_CHAN     = 10,
  parameter int          ASCII_HEX  = 1,
  parameter int          TERM       = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [3:0]              chan,
  input  logic [8*DATA_BYTES-1:0] datos,
  output logic                    tx,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int BAUD_W  = $clog2(CLK_DIV);
  localparam int PAY_LEN = DATA_BYTES * ((ASCII_HEX != 0) ? 2 : 1);
  localparam int PAY_END = PREFIX_LEN + 2 + PAY_LEN;
  localparam int MSG_LEN = PAY_END + ((TERM != 0) ? 2 : 0);

  localparam logic [4:0]        LAST_IDX = 5'(MSG_LEN - 1);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]              state;
  logic [3:0]              chan_q;
  logic [8*DATA_BYTES-1:0] datos_q;
  logic [4:0]              idx;
  logic [2:0]              bit_cnt;
  logic [BAUD_W-1:0]       baud;
  logic [7:0]              byte_q;

  logic       baud_end;
  logic       chan_ok;
  logic [4:0] sel_idx;
  logic [7:0] byte_next;
  logic [7:0] pay_byte;
  logic [3:0] nib;
  int         pos;
  int         off;

  assign baud_end = (baud == BAUD_MAX);
  assign chan_ok  = ({28'd0, chan} < 32'(N_CHAN));
  // During the stop bit look one byte ahead so the next frame starts without a gap.
  assign sel_idx  = (state == S_STOP) ? idx + 5'd1 : idx;

  // Byte selected by sel_idx out of the latched fields.
  always_comb begin
    pos       = int'(sel_idx);
    off       = pos - PREFIX_LEN - 2;
    pay_byte  = 8'h00;
    nib       = 4'h0;
    byte_next = 8'h00;
    if (pos < PREFIX_LEN) begin
      byte_next = 8'(PREFIX >> (8 * (PREFIX_LEN - 1 - pos)));
    end else if (pos == PREFIX_LEN) begin
      byte_next = 8'h30 + {4'h0, chan_q};
    end else if (pos == PREFIX_LEN + 1) begin
      byte_next = 8'h3A;
    end else if (pos < PAY_END) begin
      if (ASCII_HEX != 0) begin
        // Two characters per payload byte, high nibble first.
        pay_byte  = 8'(datos_q >> (8 * (DATA_BYTES - 1 - (off / 2))));
        nib       = off[0] ? pay_byte[3:0] : pay_byte[7:4];
        byte_next = (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
      end else begin
        byte_next = 8'(datos_q >> (8 * (DATA_BYTES - 1 - off)));
      end
    end else if ((TERM != 0) && (pos == PAY_END)) begin
      byte_next = 8'h0D;
    end else if ((TERM != 0) && (pos == PAY_END + 1)) begin
      byte_next = 8'h0A;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      chan_q  <= '0;
      datos_q <= '0;
      idx     <= '0;
      bit_cnt <= '0;
      baud    <= '0;
      byte_q  <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (chan_ok) begin
              chan_q  <= chan;
              datos_q <= datos;
              idx     <= '0;
              busy    <= 1'b1;
              state   <= S_LOAD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          byte_q <= byte_next;
          baud   <= '0;
          tx     <= 1'b0;
          state  <= S_START;
        end
        S_START: begin
          if (baud_end) begin
            baud    <= '0;
            bit_cnt <= '0;
            tx      <= byte_q[0];
            state   <= S_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= byte_q[bit_cnt + 3'd1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_STOP: begin
          byte_q <= byte_next;
          if (baud_end) begin
            baud <= '0;
            if (idx == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              idx   <= idx + 5'd1;
              tx    <= 1'b0;
              state <= S_START;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_DONE: begin
          idx   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
